fetch_queue_stage: RTL
======================

Name: fetch_queue_stage

Overview:
- Parametrised next-generation fetch stage.
- Generates sequential PCs and issues requests to a pipelined, in-order instruction memory with valid/ready handshake and variable latency.
- Buffers responses in a DEPTH-entry instruction queue that feeds decode over a valid/ready handshake.
- Handles redirects (branch/jump/flush) by discarding queued and in-flight instructions. Sits between the PC-redirect logic and the decode stage.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- DEPTH, 4, instruction queue entries; also the maximum in-flight plus queued instructions (power of two, >=2).
- RESET_ADDR, 0, PC value after reset.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- redirect_valid  in  1  flush and restart fetch at redirect_addr.
- redirect_addr  in  XLEN  new fetch PC.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address (current PC).
- imem_rsp_valid  in  1  response valid, one per accepted request, in order.
- imem_rsp_data  in  XLEN  instruction word.
- fetch_valid  out  1  queue head valid.
- fetch_ready  in  1  decode accepts head.
- fetch_instr  out  XLEN  head instruction.
- fetch_instr_addr  out  XLEN  head PC.
- fetch_instr_addr_plus  out  XLEN  head PC + 4.
- fetch_misaligned  out  1  only with FETCH_MISALIGN_EN (see below).

Behaviour:
- Reset:
  - PC = RESET_ADDR.
  - Queue empty; fetch_valid = 0; fetch_instr/addr/addr_plus = 0.
  - outstanding = 0; discard = 0.
  - imem_req_valid = 0 while rst is high.
  - Reset mid-operation drops everything. Responses arriving after reset for pre-reset requests are not tracked; the memory is reset in the same cycle.
- Credit:
  - credit_ok = (queue_count + outstanding) < DEPTH.
  - imem_req_valid = ~rst & credit_ok & ~redirect_valid. Combinational; imem_req_addr = PC register.
- Request accepted (valid & ready): PC <= PC + 4 (mod 2^XLEN, wraps silently); outstanding++.
- Response:
  - outstanding-- on every imem_rsp_valid.
  - If discard > 0: discard--, data dropped.
  - Otherwise push {PC_of_request, data} into queue. Request PCs are tracked in a DEPTH-entry address FIFO written on request acceptance.
  - Pushed entries are visible on fetch outputs the next cycle. There is no bypass.
- Minimum latency: request at cycle T, response at T+1, fetch_valid at T+2.
- Output handshake:
  - Head is popped when fetch_valid & fetch_ready.
  - Outputs are driven from the queue head and hold stable while fetch_valid & ~fetch_ready.
- Simultaneous push and pop on a full queue is legal; count is unchanged. The credit rule guarantees no push into a full queue without a pop.
- Redirect cycle (redirect_valid = 1):
  - No request is issued.
  - Queue cleared, including any head popped that cycle; decode flushes on redirect too.
  - Next PC = redirect_addr.
  - discard <= outstanding minus responses arriving this cycle.
  - Response arriving in the redirect cycle is dropped.
  - Address FIFO cleared of in-flight entries; discarded responses pop nothing.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- Redirect with outstanding = 0: discard = 0 and fetch resumes at redirect_addr the next cycle.
- New responses are accepted only after discard reaches 0. Memory ordering guarantees correctness.
- fetch_instr_addr_plus = fetch_instr_addr + 4, registered with the entry. It is 0 whenever the queue is empty.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- With the macro:
  - Redirect whose redirect_addr[1:0] != 0 issues no memory request.
  - Instead, one queue entry is pushed the next cycle with fetch_misaligned = 1, fetch_instr = 0, and fetch_instr_addr = redirect_addr.
  - Fetch then halts (imem_req_valid = 0) until the next redirect or reset.
  - fetch_misaligned is 0 for all normal entries.
- Without the macro:
  - Port is absent; redirect_addr[1:0] is ignored and forced to 00.
  - Fetch continues from the aligned address.

Test Plan:
- Reset with RESET_ADDR = 0x100, memory latency 1, ready always 1, fetch_ready always 1 -> requests 0x100, 0x104, 0x108...; fetch_valid first high 2 cycles after rst falls; fetch_instr_addr_plus = 0x104 with addr 0x100.
- fetch_ready held 0 for 10 cycles, DEPTH = 4 -> at most 4 requests issued, then imem_req_valid = 0; head stable at 0x0. On release, 4 consecutive pops, then streaming resumes with no gap after refill.
- Memory latency 3, redirect to 0x2000 while 2 requests in flight -> both responses dropped; next fetch_valid entry has addr 0x2000 with correct data; no stale 0x0xx entry appears.
- Redirect in the same cycle as a response and a head pop -> response dropped, queue empty next cycle, PC = redirect_addr; discard count correct (check via no stale output).
- imem_req_ready toggling 1/0 randomly, PC wrap from 0xFFFFFFFC -> next request addr 0x00000000, fetch_instr_addr_plus = 0x00000000.
- FETCH_MISALIGN_EN defined, redirect to 0x2002 -> one entry with fetch_misaligned = 1, addr 0x2002, instr 0, no memory request; redirect to 0x3000 resumes normal fetch.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: sequential-PC instruction fetch with a DEPTH-entry instruction queue.
// Latency: a request accepted in cycle T returns at T+1 at the earliest, and reaches fetch_* at T+2 (no bypass).
// Backpressure: requests are issued only while queued + in-flight < DEPTH; the fetch_* head holds while fetch_ready is low.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   redirect_valid/_addr     flush queue and in-flight work, restart fetch at redirect_addr
//   imem_req_valid/_ready    request handshake to instruction memory, imem_req_addr = current PC
//   imem_rsp_valid/_data     in-order responses, one per accepted request
//   fetch_valid/_ready       queue head handshake to decode
//   fetch_instr[_addr[_plus]] head instruction, its PC and PC+4 (all zero while the queue is empty)
//   fetch_misaligned         present only when FETCH_MISALIGN_EN is defined
// Optional macro FETCH_MISALIGN_EN: a redirect to a non-word-aligned address pushes a single
// fetch_misaligned entry instead of fetching, then halts requests until the next redirect/reset.
module fetch_queue_stage #(
   parameter int              XLEN       = 32,
   parameter int              DEPTH      = 4,
   parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_addr,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] fetch_instr,
   output logic [XLEN-1:0] fetch_instr_addr,
   output logic [XLEN-1:0] fetch_instr_addr_plus
`ifdef FETCH_MISALIGN_EN
   ,
   output logic            fetch_misaligned
`endif
);

   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = PW + 1;
   localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

   // state
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   out_q, out_d;      // requests accepted but not yet answered
   logic [CW-1:0]   disc_q, disc_d;    // responses still owed to the pre-redirect path
   logic [CW-1:0]   cnt_q, cnt_d;      // instruction queue occupancy
   logic [PW-1:0]   q_rd_q, q_rd_d, q_wr_q, q_wr_d;
   logic [PW-1:0]   a_rd_q, a_rd_d, a_wr_q, a_wr_d;

   logic [XLEN-1:0] q_instr_q [DEPTH];
   logic [XLEN-1:0] q_addr_q  [DEPTH];
   logic [XLEN-1:0] q_plus_q  [DEPTH];
   logic [XLEN-1:0] a_fifo_q  [DEPTH];  // PCs of live in-flight requests

   // datapath controls
   logic [CW:0]     occ;
   logic            credit_ok;
   logic            req_fire;
   logic            rsp_keep;
   logic            push;
   logic            pop;
   logic            mis_push;
   logic            halt;
   logic [XLEN-1:0] redir_pc;
   logic [XLEN-1:0] push_instr;
   logic [XLEN-1:0] push_addr;

`ifdef FETCH_MISALIGN_EN
   logic            q_mis_q [DEPTH];
   logic            mis_pend_q, mis_pend_d;
   logic            halt_q, halt_d;
   logic [XLEN-1:0] mis_addr_q, mis_addr_d;
   logic            redir_mis;

   assign redir_mis  = redirect_valid & (redirect_addr[1:0] != 2'b00);
   assign mis_pend_d = redir_mis;
   assign halt_d     = redirect_valid ? redir_mis : halt_q;
   assign mis_addr_d = redirect_valid ? redirect_addr : mis_addr_q;

   // the misaligned entry lands the cycle after its redirect; the queue is empty then and
   // every older response is marked for discard, so it never collides with a real push
   assign mis_push   = mis_pend_q & ~redirect_valid;
   assign halt       = halt_q;
   // a misaligned PC is never sent to memory because fetch halts
   assign redir_pc   = redirect_addr;
   assign push_instr = mis_push ? '0 : imem_rsp_data;
   assign push_addr  = mis_push ? mis_addr_q : a_fifo_q[a_rd_q];
`else
   assign mis_push   = 1'b0;
   assign halt       = 1'b0;
   assign redir_pc   = redirect_addr & ~XLEN'(3);
   assign push_instr = imem_rsp_data;
   assign push_addr  = a_fifo_q[a_rd_q];
`endif

   // credit: never have more instructions queued or in flight than the queue can hold
   assign occ            = {1'b0, cnt_q} + {1'b0, out_q};
   assign credit_ok      = occ < DEPTH_C;
   assign imem_req_valid = ~rst & credit_ok & ~redirect_valid & ~halt;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign pop            = fetch_valid & fetch_ready;
   // responses only enter the queue once every stale in-flight request has drained
   assign rsp_keep       = imem_rsp_valid & (disc_q == '0) & ~redirect_valid;
   assign push           = rsp_keep | mis_push;

   always_comb begin
      pc_d   = pc_q;
      out_d  = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
      disc_d = disc_q;
      cnt_d  = cnt_q;
      q_rd_d = q_rd_q;
      q_wr_d = q_wr_q;
      a_rd_d = a_rd_q;
      a_wr_d = a_wr_q;
      if (redirect_valid) begin
         pc_d   = redir_pc;
         // everything still in flight belongs to the abandoned path
         disc_d = out_q - CW'(imem_rsp_valid);
         cnt_d  = '0;
         q_rd_d = '0;
         q_wr_d = '0;
         a_rd_d = '0;
         a_wr_d = '0;
      end else begin
         if (req_fire) begin
            pc_d   = pc_q + FOUR;
            a_wr_d = a_wr_q + PW'(1);
         end
         if (imem_rsp_valid && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
         end
         if (rsp_keep) begin
            a_rd_d = a_rd_q + PW'(1);
         end
         if (push) begin
            q_wr_d = q_wr_q + PW'(1);
         end
         if (pop) begin
            q_rd_d = q_rd_q + PW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_ADDR;
         out_q  <= '0;
         disc_q <= '0;
         cnt_q  <= '0;
         q_rd_q <= '0;
         q_wr_q <= '0;
         a_rd_q <= '0;
         a_wr_q <= '0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         disc_q <= disc_d;
         cnt_q  <= cnt_d;
         q_rd_q <= q_rd_d;
         q_wr_q <= q_wr_d;
         a_rd_q <= a_rd_d;
         a_wr_q <= a_wr_d;
      end
   end

`ifdef FETCH_MISALIGN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         mis_pend_q <= 1'b0;
         halt_q     <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         mis_pend_q <= mis_pend_d;
         halt_q     <= halt_d;
         mis_addr_q <= mis_addr_d;
      end
   end
`endif

   // storage arrays need no reset: occupancy and pointers qualify every read
   always_ff @(posedge clk) begin
      if (req_fire) begin
         a_fifo_q[a_wr_q] <= pc_q;
      end
      if (push) begin
         q_instr_q[q_wr_q] <= push_instr;
         q_addr_q[q_wr_q]  <= push_addr;
         q_plus_q[q_wr_q]  <= push_addr + FOUR;
`ifdef FETCH_MISALIGN_EN
         q_mis_q[q_wr_q]   <= mis_push;
`endif
      end
   end

   assign fetch_valid           = (cnt_q != '0);
   assign fetch_instr           = fetch_valid ? q_instr_q[q_rd_q] : '0;
   assign fetch_instr_addr      = fetch_valid ? q_addr_q[q_rd_q]  : '0;
   assign fetch_instr_addr_plus = fetch_valid ? q_plus_q[q_rd_q]  : '0;
`ifdef FETCH_MISALIGN_EN
   assign fetch_misaligned      = fetch_valid & q_mis_q[q_rd_q];
`endif

endmodule
